// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] INST_NOP    = 32'h00000013;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM and hands
// (instruction, PC) pairs to decode over a valid/ready handshake.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          LAST_WORD = 128,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [31:0]       inst_out,
    output logic [31:0]       pc_out,
    output logic              halted,
    output logic [1:0]        fetch_err
);

    localparam logic [29:0] LAST_WORD_IDX = 30'(LAST_WORD);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_p0, pc_p0_nxt;
    logic         vld_p1_nxt;
    logic [31:0]  inst_p1_nxt;
    logic [31:0]  pc_p1_nxt;
    logic [1:0]   err_nxt;
    logic         load;

    assign imem_addr = pc_p0[ADDR_W+1:2];
    assign halted    = (state == HALT);

    always_comb begin
        state_nxt   = state;
        pc_p0_nxt   = pc_p0;
        vld_p1_nxt  = inst_valid;
        inst_p1_nxt = inst_out;
        pc_p1_nxt   = pc_out;
        err_nxt     = fetch_err;
        load        = (state == RUN) && (!inst_valid || inst_ready);

        if (state == RUN) begin
            // A redirect flushes the output word and wins over any load.
            if (redirect_valid) begin
                vld_p1_nxt = 1'b0;
                if (redirect_target[1:0] != 2'b00) begin
                    err_nxt[ERR_MISALIGN] = 1'b1;
                    state_nxt             = HALT;
                end else begin
                    pc_p0_nxt = redirect_target;
                end
            end else if (load) begin
                if (pc_p0[31:2] > LAST_WORD_IDX) begin
                    err_nxt[ERR_RANGE] = 1'b1;
                    vld_p1_nxt         = 1'b0;
                    state_nxt          = HALT;
                end else begin
                    inst_p1_nxt = imem_data;
                    pc_p1_nxt   = pc_p0;
                    vld_p1_nxt  = 1'b1;
                    pc_p0_nxt   = pc_p0 + 32'd4;
                    if (imem_data == INST_EBREAK) begin
                        state_nxt = HALT;
                    end
                end
            end
        end else if (inst_valid && inst_ready) begin
            // Halted: drain a held word (e.g. the ebreak) but load nothing.
            vld_p1_nxt = 1'b0;
        end
    end

    // Stage p0 (PC) -> p1 (output register)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc_p0      <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= INST_NOP;
            pc_out     <= 32'h0;
            fetch_err  <= 2'b00;
        end else begin
            state      <= state_nxt;
            pc_p0      <= pc_p0_nxt;
            inst_valid <= vld_p1_nxt;
            inst_out   <= inst_p1_nxt;
            pc_out     <= pc_p1_nxt;
            fetch_err  <= err_nxt;
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Initiator side of the instruction-memory interface: owns the PC, drives the word address into the combinational instruction ROM and captures the returned word. Delivers (instruction, PC) pairs to decode over a valid/ready handshake. Also handles branch/jump redirects, stops on ebreak, and flags misaligned or out-of-range fetches.

Parameters:
ADDR_W, 8, width of the memory word-address port; the address is pc[ADDR_W+1:2].
LAST_WORD, 128, highest valid word index in instruction memory.
RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
imem_addr  output  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2] combinationally.
imem_data  input  32  instruction word from memory, valid in the same cycle.
redirect_valid  input  1  taken branch/jump this cycle.
redirect_target  input  32  byte address of the new PC.
inst_ready  input  1  decode accepts inst_out this cycle.
inst_valid  output  1  inst_out and pc_out hold a valid instruction.
inst_out  output  32  fetched instruction.
pc_out  output  32  byte address of inst_out.
halted  output  1  fetch has stopped (ebreak or error).
fetch_err  output  2  sticky error code: bit0 = misaligned redirect, bit1 = PC out of range.

Behaviour:
- States: RUN, HALT. Reset enters RUN. HALT is left only by reset.
- Reset values (async, immediate):
  - pc = RESET_PC
  - inst_valid = 0
  - inst_out = 32'h00000013 (NOP)
  - pc_out = 0
  - halted = 0
  - fetch_err = 0
- "load" condition: RUN and (!inst_valid or inst_ready). Latency from pc to output is 1 cycle.
- On load, at the next edge: inst_out <= imem_data, pc_out <= pc, inst_valid <= 1, pc <= pc+4.
- Backpressure: inst_valid=1 and inst_ready=0 -> pc, inst_out, pc_out and inst_valid all hold. Hold may last any number of cycles with no loss or duplication.
- Output consumed with no load possible (HALT): inst_valid <= 0.
- Redirect has the highest priority in RUN:
  - inst_valid <= 0, flushing the word in the output register.
  - pc <= redirect_target.
  - No word is loaded that cycle.
  - Applies regardless of inst_ready.
- Misaligned redirect (redirect_target[1:0] != 0): fetch_err[0] <= 1, inst_valid <= 0, state <= HALT; pc is not updated.
- Out of range (pc[31:2] > LAST_WORD while a load would occur): no load, fetch_err[1] <= 1, inst_valid <= 0, state <= HALT.
- ebreak: when the loaded word equals 32'h00100073 it is delivered normally (inst_valid=1) and state <= HALT in the same edge. No further loads; the held ebreak remains deliverable until accepted.
- halted = (state == HALT), registered.
- Redirect in the same cycle as an ebreak fetch: redirect wins, ebreak is discarded, no halt.
- Redirect while in HALT is ignored.
- ecall and fence are passed through as ordinary instructions.
- PC arithmetic is 32-bit and wraps modulo 2^32; the range check catches any wrap first.
- Reset mid-stall or mid-redirect returns every output to its reset value immediately, without waiting for a clock edge.

Decomposition:
- Shared package fetch_pkg holds:
  - INST_NOP = 32'h00000013
  - INST_EBREAK = 32'h00100073
  - fetch state encoding (RUN, HALT)
  - fetch_err bit indices
- No sub-module. The output register and PC logic are small enough to live in one module, roughly 150 lines.

Test Plan:
- Straight-line run: mem[0..2] = 0x00000013, 0x00100093, 0x00500113, inst_ready=1, release rst -> inst_valid rises 1 cycle later; outputs (0x00000013, pc 0), (0x00100093, pc 4), (0x00500113, pc 8) on consecutive cycles.
- Backpressure: hold inst_ready=0 for 3 cycles while inst_out=0x00100093/pc 4 -> output and imem_addr=2 stable for all 3 cycles; next word is pc 8 after release.
- Redirect: redirect_valid with target 0xC8 while pc_out=0x80 is held -> inst_valid=0 next cycle, imem_addr=50, then pc_out=0xC8 delivered; pc 0x84 is never delivered.
- ebreak: mem[76]=0x00100073 reached at pc 0x130 -> delivered once with pc_out 0x130; halted=1 from the next cycle; imem_addr frozen; later redirects ignored.
- Errors: redirect to 0x102 -> fetch_err=2'b01, halted=1. Separately, redirect to 0x204 (word 129) -> fetch_err=2'b10, halted=1, no inst_valid.
- Async reset: assert rst between edges during a stall -> inst_valid=0, inst_out=0x00000013 and pc_out=0 immediately; fetch restarts at pc 0 after release.
